// File: rtl/pdp8_dma_pkg.sv
// ============================================================================
// Module      : pdp8_dma_pkg
// Description : Shared state encoding, widths and helpers for pdp8_dma_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdp8_dma_pkg;

    localparam int WORD_W = 12;
    localparam int ADDR_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_MEM     = 3'd2,
        ST_INC_WR  = 3'd3,
        ST_DONE    = 3'd4,
        ST_RELEASE = 3'd5
    } dma_state_e;

    // MSB of the result is the 7777->0000 wrap flag.
    function automatic logic [WORD_W:0] inc_word(input logic [WORD_W-1:0] w);
        return {1'b0, w} + {{WORD_W{1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdp8_dma_ctl.sv
// ============================================================================
// Module      : pdp8_dma_ctl
// Description : Single-word DMA controller for a PDP-8 memory; requests the
//               CPU hold, performs one read/write, then releases the bus.
//               Optional read-increment-write selected by PDP8_DMA_RMW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdp8_dma_ctl
    import pdp8_dma_pkg::*;
#(
    parameter int MEM_LAT  = 2,
    parameter int HOLD_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_ram_read_req,
    input  logic              ext_ram_write_req,
    input  logic [ADDR_W-1:0] ext_ram_ma,
    input  logic [WORD_W-1:0] ext_ram_in,
    input  logic              ext_ram_inc_req,
    output logic              ext_ram_done,
    output logic [WORD_W-1:0] ext_ram_out,
    output logic              ext_ram_ovf,
    output logic              ext_ram_err,
    output logic              dma_hold,
    input  logic              cpu_idle,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int CNT_W = (HOLD_MAX > 8) ? $clog2(HOLD_MAX) : 3;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(MEM_LAT - 1);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] ma_q,    ma_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic [WORD_W-1:0] out_q,   out_d;
    logic              wr_q,    wr_d;
    logic              err_q,   err_d;
    logic              req_w;

`ifdef PDP8_DMA_RMW_EN
    logic              inc_q,   inc_d;
    logic              ovf_q,   ovf_d;
    logic [WORD_W:0]   inc_w;
    assign inc_w = inc_word(mem_rdata);
`else
    logic              unused_inc;
    assign unused_inc = ext_ram_inc_req;
`endif

    assign req_w = ext_ram_read_req | ext_ram_write_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            data_q  <= '0;
            out_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef PDP8_DMA_RMW_EN
            inc_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            data_q  <= data_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
`ifdef PDP8_DMA_RMW_EN
            inc_q   <= inc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        data_d  = data_q;
        out_d   = out_q;
        wr_d    = wr_q;
        err_d   = 1'b0;
`ifdef PDP8_DMA_RMW_EN
        inc_d   = inc_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_w) begin
                    ma_d    = ext_ram_ma;
                    data_d  = ext_ram_in;
                    wr_d    = ext_ram_write_req;
`ifdef PDP8_DMA_RMW_EN
                    inc_d   = ~ext_ram_write_req & ext_ram_inc_req;
`endif
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cpu_idle) begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_MEM;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MEM: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        out_d = mem_rdata;
`ifdef PDP8_DMA_RMW_EN
                        ovf_d = 1'b0;
                        if (inc_q) begin
                            // Incremented word is written back from data_q.
                            out_d   = inc_w[WORD_W-1:0];
                            data_d  = inc_w[WORD_W-1:0];
                            ovf_d   = inc_w[WORD_W];
                            cnt_d   = LAT_LOAD;
                            state_d = ST_INC_WR;
                        end
`endif
                    end
                end
            end
`ifdef PDP8_DMA_RMW_EN
            ST_INC_WR: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Requests are level-held; wait for both to drop so a
                // lingering request cannot start a second transfer.
                if (!req_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dma_hold     = (state_q == ST_HOLD) || (state_q == ST_MEM) ||
                          (state_q == ST_INC_WR) || (state_q == ST_DONE);
    assign mem_rd       = (state_q == ST_MEM) && !wr_q;
    assign mem_wr       = ((state_q == ST_MEM) && wr_q) || (state_q == ST_INC_WR);
    assign mem_addr     = ma_q;
    assign mem_wdata    = data_q;
    assign ext_ram_out  = out_q;
    assign ext_ram_done = (state_q == ST_DONE);
    assign ext_ram_err  = err_q;

`ifdef PDP8_DMA_RMW_EN
    assign ext_ram_ovf  = ovf_q;
`else
    assign ext_ram_ovf  = 1'b0;
`endif

endmodule

`default_nettype wire
